// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues byte/halfword/word accesses on a request/acknowledge
// bus, holds the pipeline until the access completes and returns extended load data.
module load_store_unit #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [2:0]    mem_op,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          flush,
    output logic          stall,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          adel,
    output logic          ades,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic          bus_ack,
    input  logic [31:0]   bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} stateT;
    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } memOpT;

    stateT       state, nextState;
    memOpT       curOp, opQ;
    logic [1:0]  laneQ;
    logic        isLoad, misaligned, start;
    logic [3:0]  nextBe;
    logic [31:0] nextWdata;
    logic        opQIsLoad;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;

    assign curOp = memOpT'(mem_op);

    // Decode of the incoming M-stage request: direction, alignment, lane enables and data.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned
        // (an unassigned path in combinational logic infers a latch).
        isLoad     = 1'b1;
        misaligned = 1'b0;
        nextBe     = 4'b1111;
        nextWdata  = wdata;
        case (curOp)
            OP_LH, OP_LHU: misaligned = addr[0];
            OP_LW:         misaligned = |addr[1:0];
            OP_SB: begin
                isLoad    = 1'b0;
                nextBe    = 4'b0001 << addr[1:0];
                nextWdata = {4{wdata[7:0]}};
            end
            OP_SH: begin
                isLoad     = 1'b0;
                misaligned = addr[0];
                nextBe     = addr[1] ? 4'b1100 : 4'b0011;
                nextWdata  = {2{wdata[15:0]}};
            end
            OP_SW: begin
                isLoad     = 1'b0;
                misaligned = |addr[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        nextState = state;
        start     = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        adel      = 1'b0;
        ades      = 1'b0;
        case (state)
            IDLE: begin
                start = req_valid & ~flush & ~misaligned;
                adel  = req_valid & ~flush & misaligned & isLoad;
                ades  = req_valid & ~flush & misaligned & ~isLoad;
                stall = start;
                if (start) nextState = REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ack) nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Extraction uses the latched op/lane, so M-stage inputs may change while REQ waits.
    always_comb begin
        byteSel   = 8'(bus_rdata >> {laneQ, 3'b000});
        halfSel   = 16'(bus_rdata >> {laneQ[1], 4'b0000});
        opQIsLoad = 1'b1;
        loadData  = bus_rdata;
        case (opQ)
            OP_LB:  loadData = {{24{byteSel[7]}}, byteSel};
            OP_LBU: loadData = {24'd0, byteSel};
            OP_LH:  loadData = {{16{halfSel[15]}}, halfSel};
            OP_LHU: loadData = {16'd0, halfSel};
            OP_LW:  loadData = bus_rdata;
            default: opQIsLoad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opQ       <= OP_LB;
            laneQ     <= 2'b00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'd0;
            rdata     <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= nextState;
            if (start) begin
                opQ       <= curOp;
                laneQ     <= addr[1:0];
                bus_addr  <= {addr[AW-1:2], 2'b00};
                bus_be    <= nextBe;
                bus_wdata <= nextWdata;
                bus_we    <= ~isLoad;
                bus_req   <= 1'b1;
            end else if (state == REQ && bus_ack) begin
                bus_req <= 1'b0;
                if (opQIsLoad) rdata <= loadData;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a timeline model predicts every output from the
// access start cycle and ack wait count; directed literals pin the model's arithmetic.
module tb_load_store_unit;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4,
                           SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, flush, bus_ack;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stall, done, adel, ades, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: the access in flight, described by its start cycle and waits.
    logic        mActive = 1'b0;
    logic        mStarts = 1'b0;
    logic        mFlush = 1'b0;
    logic [2:0]  mOp = 3'd0;
    logic [31:0] mAddr = 32'd0, mWdata = 32'd0;
    int          mT0 = 0, mW = 0;
    logic [31:0] mLastRdata = 32'd0, mDoneRdata = 32'd0;

    int          sStallCnt;
    logic [31:0] sBusAddr, sWd, sRdata;
    logic [3:0]  sBe;
    logic        sWe, sAdel, sAdes;

    load_store_unit #(.AW(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_op(mem_op), .addr(addr),
        .wdata(wdata), .flush(flush), .stall(stall), .done(done), .rdata(rdata),
        .adel(adel), .ades(ades), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic isLd(input logic [2:0] op);
        return op <= LW;
    endfunction

    function automatic logic misAl(input logic [2:0] op, input logic [31:0] a);
        if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
        if (op == LW || op == SW) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] expBe(input logic [2:0] op, input logic [31:0] a);
        if (op == SB) return 4'(1 << (a % 4));
        if (op == SH) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] expWd(input logic [2:0] op, input logic [31:0] wd);
        if (op == SB) return (wd & 32'hFF) * 32'h0101_0101;
        if (op == SH) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * (a % 4))) & 32'hFF;
        h = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (op)
            LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            LBU:     return b;
            LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            LHU:     return h;
            default: return word;
        endcase
    endfunction

    // Compare process: every cycle, outputs are predicted from position within the access.
    always @(negedge clk) begin
        int k;
        logic eStall, eDone, eReq, eAdel, eAdes;
        logic [31:0] eR;
        k = cyc - mT0;
        eStall = 1'b0; eDone = 1'b0; eReq = 1'b0; eAdel = 1'b0; eAdes = 1'b0;
        eR = mLastRdata;
        if (rst) begin
            eR = 32'd0;
        end else if (mActive) begin
            if (mStarts) begin
                eStall = (k <= mW + 1);
                eReq   = (k >= 1) && (k <= mW + 1);
                eDone  = (k == mW + 2);
                if (eDone) eR = mDoneRdata;
            end else if (k == 0 && !mFlush && misAl(mOp, mAddr)) begin
                eAdel = isLd(mOp);
                eAdes = !isLd(mOp);
            end
        end
        check("stall", stall, eStall);
        check("done", done, eDone);
        check("bus_req", bus_req, eReq);
        check("adel", adel, eAdel);
        check("ades", ades, eAdes);
        check("rdata", rdata, eR);
        if (eReq) begin
            check("bus_addr", bus_addr, mAddr & 32'hFFFF_FFFC);
            check("bus_be", bus_be, expBe(mOp, mAddr));
            check("bus_we", bus_we, !isLd(mOp));
            if (!isLd(mOp)) check("bus_wdata", bus_wdata, expWd(mOp, mWdata));
        end
    end

    // Called at posedge+1; drives one whole access, with the bus responder acking after w waits.
    task automatic access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input int w, input logic fl, input logic [31:0] word);
        int last;
        mOp = op; mAddr = a; mWdata = wd; mW = w; mFlush = fl; mT0 = cyc;
        mStarts = !fl && !misAl(op, a);
        mDoneRdata = isLd(op) ? expLoad(op, a, word) : mLastRdata;
        mActive = 1'b1;
        last = mStarts ? w + 2 : 0;
        sStallCnt = 0;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            req_valid = 1'b1;
            if (k == 0) begin
                mem_op = op; addr = a; wdata = wd; flush = fl;
                bus_ack = 1'($urandom % 2);
                bus_rdata = $urandom;
            end else begin
                mem_op = 3'($urandom); addr = $urandom; wdata = $urandom;
                flush = 1'($urandom % 2);
                bus_ack = (k == w + 1) ? 1'b1 : (k == w + 2) ? 1'($urandom % 2) : 1'b0;
                bus_rdata = (k == w + 1) ? word : $urandom;
            end
            @(negedge clk);
            if (stall) sStallCnt++;
            if (k == 0) begin
                sAdel = adel; sAdes = ades;
            end
            if (k == 1) begin
                sBusAddr = bus_addr; sBe = bus_be; sWd = bus_wdata; sWe = bus_we;
            end
            if (k == last) sRdata = rdata;
        end
        @(posedge clk); #1;
        mActive = 1'b0;
        if (mStarts) mLastRdata = mDoneRdata;
        req_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'($urandom % 2);
            flush = 1'b1;
            mem_op = 3'($urandom); addr = $urandom; wdata = $urandom;
            bus_ack = 1'($urandom % 2);
            bus_rdata = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0;
        mem_op = 3'd0; addr = 32'd0; wdata = 32'd0; bus_rdata = 32'd0;
        @(negedge clk);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", bus_be, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_bus_we", bus_we, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idleCycles(2);

        access(LW, 32'h100, 32'd0, 1, 1'b0, 32'hDEAD_BEEF);
        check("lw_bus_addr", sBusAddr, 32'h100);
        check("lw_be", sBe, 4'b1111);
        check("lw_we", sWe, 1'b0);
        check("lw_stall_cycles", sStallCnt, 3);
        check("lw_rdata", sRdata, 32'hDEAD_BEEF);

        access(LB, 32'h203, 32'd0, 0, 1'b0, 32'h8012_3456);
        check("lb_rdata", sRdata, 32'hFFFF_FF80);
        access(LBU, 32'h203, 32'd0, 0, 1'b0, 32'h8012_3456);
        check("lbu_rdata", sRdata, 32'h0000_0080);
        access(LHU, 32'h202, 32'd0, 0, 1'b0, 32'h8001_F00F);
        check("lhu_rdata", sRdata, 32'h0000_8001);
        access(LH, 32'h200, 32'd0, 0, 1'b0, 32'h8001_F00F);
        check("lh_rdata", sRdata, 32'hFFFF_F00F);

        access(SB, 32'h13, 32'h0000_00A5, 0, 1'b0, 32'd0);
        check("sb_bus_addr", sBusAddr, 32'h10);
        check("sb_be", sBe, 4'b1000);
        check("sb_wdata", sWd, 32'hA5A5_A5A5);
        check("sb_we", sWe, 1'b1);
        check("sb_rdata_kept", sRdata, 32'hFFFF_F00F);
        access(SH, 32'h12, 32'h0000_1234, 0, 1'b0, 32'd0);
        check("sh_be", sBe, 4'b1100);
        check("sh_wdata", sWd, 32'h1234_1234);

        access(LW, 32'h102, 32'd0, 0, 1'b0, 32'd0);
        check("lw_mis_adel", sAdel, 1'b1);
        check("lw_mis_stall", sStallCnt, 0);
        idleCycles(1);
        access(SH, 32'h101, 32'd0, 0, 1'b0, 32'd0);
        check("sh_mis_ades", sAdes, 1'b1);
        access(LW, 32'h102, 32'd0, 0, 1'b1, 32'd0);
        check("lw_flush_adel", sAdel, 1'b0);
        check("lw_flush_stall", sStallCnt, 0);

        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom);
            a = $urandom;
            if ($urandom % 4 != 0) begin
                if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
                if (op == LW || op == SW) a[1:0] = 2'b00;
            end
            access(op, a, $urandom, int'($urandom % 4), 1'($urandom % 10 == 0), $urandom);
            idleCycles(int'($urandom % 3));
        end

        // Reset in the middle of a transfer whose ack is withheld.
        mOp = LW; mAddr = 32'h300; mWdata = 32'd0; mW = 1000; mFlush = 1'b0;
        mStarts = 1'b1; mT0 = cyc; mActive = 1'b1;
        req_valid = 1'b1; mem_op = LW; addr = 32'h300; flush = 1'b0; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst = 1'b1; req_valid = 1'b0;
        mActive = 1'b0; mLastRdata = 32'd0;
        #1;
        check("rst_mid_bus_req", bus_req, 1'b0);
        check("rst_mid_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = $urandom;
        @(negedge clk);
        check("late_ack_done", done, 1'b0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("late_ack_done_next", done, 1'b0);
        @(posedge clk); #1;
        access(LW, 32'h40, 32'd0, 0, 1'b0, 32'h1357_9BDF);
        check("recover_rdata", sRdata, 32'h1357_9BDF);
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
